// File: rtl/acc_crossbar_pkg.sv
// Shared definitions for the accumulator crossbar: default sizing and the
// operation encoding carried on req_op.
package acc_crossbar_pkg;

    localparam int N_CORE   = 4;
    localparam int N_ACC    = 4;
    localparam int ACC_OP_W = 2;

    typedef enum logic [ACC_OP_W-1:0] {
        ACC_ADD = 2'b00,
        ACC_SET = 2'b01,
        ACC_CLR = 2'b10,
        ACC_MAX = 2'b11
    } acc_op_t;

endpackage

// File: rtl/acc_crossbar_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer just past the winner when the grant is taken.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               cand;

    // Grants are forced low during reset so no handshake can complete then.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!found && !rst && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        ptr_d = IDX_W'((int'(grant_idx) + 1) % N);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/acc_crossbar.sv
// Shared accumulator bank: each accumulator has its own round-robin arbiter
// over all cores, and every accumulator value is broadcast back to all cores.
module acc_crossbar
    import acc_crossbar_pkg::acc_op_t, acc_crossbar_pkg::ACC_ADD, acc_crossbar_pkg::ACC_SET,
           acc_crossbar_pkg::ACC_CLR, acc_crossbar_pkg::ACC_MAX;
#(
    parameter int N_CORE = acc_crossbar_pkg::N_CORE,
    parameter int N_ACC  = acc_crossbar_pkg::N_ACC,
    parameter int W      = 32,
    parameter int CNT_W  = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [N_CORE*N_ACC-1:0]                         req_valid,
    input  logic [acc_crossbar_pkg::ACC_OP_W*N_CORE*N_ACC-1:0] req_op,
    input  logic [W*N_CORE*N_ACC-1:0]                       req_wdata,
    output logic [N_CORE*N_ACC-1:0]                         req_ready,
    output logic [W*N_ACC-1:0]                              acc_data,
    output logic [CNT_W*N_ACC-1:0]                          grant_cnt,
    output logic                                            busy
);

    localparam int OP_W  = acc_crossbar_pkg::ACC_OP_W;
    localparam int IDX_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;

    assign busy = |req_valid;

    for (genvar gi = 0; gi < N_ACC; gi++) begin : g_acc
        logic [N_CORE-1:0] col_req;
        logic [N_CORE-1:0] col_grant;
        logic [IDX_W-1:0]  win_idx;
        logic              hs;
        acc_op_t           op_sel;
        logic [W-1:0]      wdata_sel;
        logic [W-1:0]      acc_q;
        logic [W-1:0]      acc_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;

        for (genvar gc = 0; gc < N_CORE; gc++) begin : g_core
            assign col_req[gc]                = req_valid[gc*N_ACC + gi];
            assign req_ready[gc*N_ACC + gi]   = col_grant[gc];
        end

        rr_arbiter #(.N(N_CORE)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (col_req),
            .advance   (hs),
            .grant     (col_grant),
            .grant_idx (win_idx)
        );

        assign hs = |col_grant;

        always_comb begin
            op_sel    = acc_op_t'(req_op[(int'(win_idx)*N_ACC + gi)*OP_W +: OP_W]);
            wdata_sel = req_wdata[(int'(win_idx)*N_ACC + gi)*W +: W];
            acc_d     = acc_q;
            unique case (op_sel)
                ACC_ADD: acc_d = acc_q + wdata_sel;
                ACC_SET: acc_d = wdata_sel;
                ACC_CLR: acc_d = '0;
                ACC_MAX: if ($signed(wdata_sel) > $signed(acc_q)) acc_d = wdata_sel;
                default: acc_d = acc_q;
            endcase
            // Statistics saturate rather than wrap so a long run never looks idle.
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (hs) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end

        assign acc_data[gi*W +: W]          = acc_q;
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_acc_crossbar.sv
// Randomised and directed bench for acc_crossbar against a queue-free
// behavioural model of the arbitration and accumulate rules.
module tb_acc_crossbar;

    localparam int NC = 4;
    localparam int NA = 4;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int NR = NC*NA;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [2*NR-1:0] req_op;
    logic [W*NR-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [W*NA-1:0] acc_data;
    logic [CW*NA-1:0] grant_cnt;
    logic            busy;

    int n_cmp;
    int n_fail;

    logic [31:0] m_acc [NA];
    int          m_cnt [NA];
    int          m_ptr [NA];

    acc_crossbar #(.N_CORE(NC), .N_ACC(NA), .W(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .acc_data  (acc_data),
        .grant_cnt (grant_cnt),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int winner(int j);
        for (int k = 0; k < NC; k++) begin
            int c;
            c = (m_ptr[j] + k) % NC;
            if (req_valid[c*NA + j]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        r = '0;
        for (int j = 0; j < NA; j++) begin
            int w;
            w = winner(j);
            if (w >= 0) r[w*NA + j] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NA; j++) begin
            m_acc[j] = '0;
            m_cnt[j] = 0;
            m_ptr[j] = 0;
        end
    endtask

    task automatic model_commit();
        for (int j = 0; j < NA; j++) begin
            int w;
            logic [1:0]  op;
            logic [31:0] d;
            w = winner(j);
            if (w >= 0) begin
                op = req_op[(w*NA + j)*2 +: 2];
                d  = req_wdata[(w*NA + j)*W +: W];
                case (op)
                    OP_ADD: m_acc[j] = m_acc[j] + d;
                    OP_SET: m_acc[j] = d;
                    OP_CLR: m_acc[j] = '0;
                    default: if ($signed(d) > $signed(m_acc[j])) m_acc[j] = d;
                endcase
                if (m_cnt[j] < (1 << CW) - 1) m_cnt[j] = m_cnt[j] + 1;
                m_ptr[j] = (w + 1) % NC;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op    = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(int i, int j, logic [1:0] op, logic [31:0] d);
        req_valid[i*NA + j]         = 1'b1;
        req_op[(i*NA + j)*2 +: 2]   = op;
        req_wdata[(i*NA + j)*W +: W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        model_reset();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            req_valid = NR'($urandom);
            #1;
            n_cmp++;
            if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready cyc=%0d got=%h exp=0", c, req_ready); end
            n_cmp++;
            if (acc_data !== '0) begin n_fail++; $display("FAIL reset_acc cyc=%0d got=%h exp=0", c, acc_data); end
            n_cmp++;
            if (grant_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt cyc=%0d got=%h exp=0", c, grant_cnt); end
            n_cmp++;
            if (busy !== (req_valid != '0)) begin n_fail++; $display("FAIL reset_busy cyc=%0d got=%b exp=%b", c, busy, (req_valid != '0)); end
            $display("reset cycle %0d valid=%h ready=%h", c, req_valid, req_ready);
            @(negedge clk);
        end
        clear_reqs();
        rst = 1'b0;
        @(negedge clk);
        set_req(2, 0, OP_ADD, 32'd5);
        #1;
        n_cmp++;
        if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL first_add_ready got=%h exp=%h", req_ready, exp_ready()); end
        tick();
        clear_reqs();
        n_cmp++;
        if (acc_data[0 +: W] !== 32'd5) begin n_fail++; $display("FAIL first_add_acc got=%h exp=5", acc_data[0 +: W]); end
        $display("first ADD 5 core2->acc0 acc0=%h", acc_data[0 +: W]);
    endtask

    task automatic test_round_robin();
        int order [6];
        order = '{0, 1, 3, 0, 1, 3};
        clear_reqs();
        set_req(0, 1, OP_ADD, 32'd1);
        set_req(1, 1, OP_ADD, 32'd1);
        set_req(3, 1, OP_ADD, 32'd1);
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rr_ready cyc=%0d got=%h exp=%h", c, req_ready, exp_ready()); end
            n_cmp++;
            if (req_ready[order[c]*NA + 1] !== 1'b1) begin n_fail++; $display("FAIL rr_order cyc=%0d ready=%h exp_core=%0d", c, req_ready, order[c]); end
            $display("rr cycle %0d ready=%h expected core %0d", c, req_ready, order[c]);
            tick();
        end
        clear_reqs();
        n_cmp++;
        if (acc_data[1*W +: W] !== 32'd6) begin n_fail++; $display("FAIL rr_acc got=%h exp=6", acc_data[1*W +: W]); end
        n_cmp++;
        if (grant_cnt[1*CW +: CW] !== 4'd6) begin n_fail++; $display("FAIL rr_cnt got=%0d exp=6", grant_cnt[1*CW +: CW]); end
    endtask

    task automatic test_parallel();
        clear_reqs();
        set_req(0, 0, OP_SET, 32'h10);
        set_req(1, 2, OP_SET, 32'h20);
        #1;
        n_cmp++;
        if (req_ready[0] !== 1'b1 || req_ready[1*NA + 2] !== 1'b1) begin
            n_fail++; $display("FAIL par_ready got=%h exp bits 0 and 6", req_ready);
        end
        tick();
        clear_reqs();
        n_cmp++;
        if (acc_data[0 +: W] !== 32'h10) begin n_fail++; $display("FAIL par_acc0 got=%h exp=10", acc_data[0 +: W]); end
        n_cmp++;
        if (acc_data[2*W +: W] !== 32'h20) begin n_fail++; $display("FAIL par_acc2 got=%h exp=20", acc_data[2*W +: W]); end
        $display("parallel SET acc0=%h acc2=%h", acc_data[0 +: W], acc_data[2*W +: W]);
    endtask

    task automatic test_arith_edges();
        logic [1:0]  ops  [6];
        logic [31:0] dat  [6];
        logic [31:0] expv [6];
        ops  = '{OP_SET, OP_ADD, OP_SET, OP_MAX, OP_MAX, OP_CLR};
        dat  = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h3, 32'h8000_0000, 32'hDEAD_BEEF};
        expv = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h3, 32'h3, 32'h0};
        for (int s = 0; s < 6; s++) begin
            clear_reqs();
            set_req(3, 2, ops[s], dat[s]);
            tick();
            clear_reqs();
            n_cmp++;
            if (acc_data[2*W +: W] !== expv[s]) begin n_fail++; $display("FAIL arith_acc step=%0d got=%h exp=%h", s, acc_data[2*W +: W], expv[s]); end
            n_cmp++;
            if (int'(grant_cnt[2*CW +: CW]) !== m_cnt[2]) begin n_fail++; $display("FAIL arith_cnt step=%0d got=%0d exp=%0d", s, grant_cnt[2*CW +: CW], m_cnt[2]); end
            $display("arith step %0d op=%0d d=%h acc2=%h cnt2=%0d", s, ops[s], dat[s], acc_data[2*W +: W], grant_cnt[2*CW +: CW]);
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 20; c++) begin
            clear_reqs();
            set_req(int'($urandom_range(0, NC-1)), 3, OP_ADD, $urandom);
            #1;
            n_cmp++;
            if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL sat_ready cyc=%0d got=%h exp=%h", c, req_ready, exp_ready()); end
            tick();
            n_cmp++;
            if (int'(grant_cnt[3*CW +: CW]) !== m_cnt[3]) begin n_fail++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", c, grant_cnt[3*CW +: CW], m_cnt[3]); end
            $display("sat cycle %0d cnt3=%0d", c, grant_cnt[3*CW +: CW]);
        end
        clear_reqs();
        n_cmp++;
        if (grant_cnt[3*CW +: CW] !== 4'd15) begin n_fail++; $display("FAIL sat_final got=%0d exp=15", grant_cnt[3*CW +: CW]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = NR'($urandom) & NR'($urandom);
            req_op    = (2*NR)'($urandom);
            for (int s = 0; s < NR; s++) req_wdata[s*W +: W] = $urandom;
            #1;
            n_cmp++;
            if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%h exp=%h", c, req_ready, exp_ready()); end
            n_cmp++;
            if (busy !== (req_valid != '0)) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b", c, busy); end
            tick();
            for (int j = 0; j < NA; j++) begin
                n_cmp++;
                if (acc_data[j*W +: W] !== m_acc[j]) begin n_fail++; $display("FAIL rand_acc cyc=%0d acc=%0d got=%h exp=%h", c, j, acc_data[j*W +: W], m_acc[j]); end
                n_cmp++;
                if (int'(grant_cnt[j*CW +: CW]) !== m_cnt[j]) begin n_fail++; $display("FAIL rand_cnt cyc=%0d acc=%0d got=%0d exp=%0d", c, j, grant_cnt[j*CW +: CW], m_cnt[j]); end
            end
            $display("rand cycle %0d valid=%h ready=%h", c, req_valid, req_ready);
        end
        clear_reqs();
    endtask

    task automatic test_mid_reset();
        clear_reqs();
        set_req(1, 0, OP_SET, 32'h55);
        tick();
        clear_reqs();
        set_req(0, 0, OP_ADD, 32'd7);
        set_req(2, 0, OP_ADD, 32'd9);
        set_req(3, 0, OP_ADD, 32'd11);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL midrst_ready got=%h exp=0", req_ready); end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        n_cmp++;
        if (acc_data !== '0) begin n_fail++; $display("FAIL midrst_acc got=%h exp=0", acc_data); end
        n_cmp++;
        if (grant_cnt !== '0) begin n_fail++; $display("FAIL midrst_cnt got=%h exp=0", grant_cnt); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready[0] !== 1'b1 || req_ready !== exp_ready()) begin n_fail++; $display("FAIL midrst_winner got=%h exp=%h", req_ready, exp_ready()); end
        tick();
        clear_reqs();
        n_cmp++;
        if (acc_data[0 +: W] !== 32'd7) begin n_fail++; $display("FAIL midrst_acc0 got=%h exp=7", acc_data[0 +: W]); end
        $display("mid-reset reissue acc0=%h", acc_data[0 +: W]);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_parallel();
        test_arith_edges();
        test_saturation();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_crossbar.md
Name: acc_crossbar

Overview:
- Shared accumulator bank used between all cores of the multi-core top: N_CORE requesters, N_ACC word-wide accumulators.
- Replaces the fixed core-to-accumulator wiring with a parametrised crossbar.
  - Each accumulator has its own round-robin arbiter.
  - Four operation modes; every core sees every accumulator's value through a broadcast readback.
- The parent core (CORE_I 0) and the child cores connect identically.

Parameters:
- N_CORE, 4, number of requesting cores (>=1)
- N_ACC, 4, number of accumulators (>=1)
- W, 32, accumulator and operand width in bits
- CNT_W, 16, width of the per-accumulator grant statistics counter

Ports:
- clk  in  1  system clock (clk_wiz output)
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_CORE*N_ACC  request from core i to accumulator j, bit i*N_ACC+j
- req_op  in  2*N_CORE*N_ACC  operation per request (acc_op_t), same indexing
- req_wdata  in  W*N_CORE*N_ACC  operand per request, same indexing
- req_ready  out  N_CORE*N_ACC  grant; the handshake completes on valid&ready at the clk edge
- acc_data  out  W*N_ACC  registered accumulator values, broadcast to all cores
- grant_cnt  out  CNT_W*N_ACC  saturating count of completed handshakes per accumulator
- busy  out  1  OR of all req_valid bits

Behaviour:
- Reset (async, active-high):
  - acc_data = 0, grant_cnt = 0.
  - All round-robin pointers = 0.
  - req_ready is combinational; it is 0 while rst = 1.
- Arbitration, per accumulator j, independent of the other accumulators:
  - Candidates are the cores i with req_valid[i][j] = 1.
  - The winner is the first candidate at index >= ptr[j], wrapping modulo N_CORE.
  - req_ready[winner][j] = 1 in the same cycle (combinational). All other ready bits for j are 0.
  - On a handshake, ptr[j] <= (winner+1) mod N_CORE at the edge. With no request, ptr[j] holds.
- One core may be granted on several accumulators in the same cycle; these grants are independent.
- Requesters must hold valid, op and wdata stable until ready. The block does not check this.
- Operations (acc_op_t) apply at the handshake edge; the new value is visible on acc_data the next cycle (latency 1):
  - ADD (00): acc <= acc + wdata, wraps modulo 2^W, no overflow flag.
  - SET (01): acc <= wdata.
  - CLR (10): acc <= 0; wdata is ignored.
  - MAX (11): acc <= max(acc, wdata), signed two's-complement compare; acc holds on a tie.
- Back-to-back handshakes on the same accumulator in consecutive cycles each see the previous result. There is no forwarding hazard because acc_data is the state register.
- grant_cnt[j]:
  - Increments by 1 on each handshake on j.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - A CLR operation does not reset it; only rst does.
- N_CORE = 1: arbiter degenerates; req_ready = req_valid, ptr is constant 0.
- Reset asserted mid-operation: a pending request is dropped, with no partial update. Requesters re-issue after rst deasserts.
- busy is purely combinational and has no registered state.

Decomposition:
- Shared package (common.vh / common package), next to N_CORE and N_ACC:
  - acc_op_t enum: ACC_ADD, ACC_SET, ACC_CLR, ACC_MAX.
  - localparam ACC_OP_W = 2.
  - The top passes the package N_CORE and N_ACC into the parameters.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: clk, rst, req[N], advance.
  - Outputs: grant[N] one-hot, grant_idx.
  - Holds the pointer; N_ACC instances are generated.
- The datapath (op mux, signed compare, saturating counter) stays in acc_crossbar.

Test Plan:
- Reset: drive rst=1 with random req_valid -> acc_data = 0, grant_cnt = 0 and req_ready = 0 throughout; after release, the first ADD 5 to acc 0 from core 2 -> acc_data[0] = 5 on the next cycle.
- Round-robin fairness: cores 0, 1, 3 hold valid on acc 1 with ADD 1 for 6 cycles -> grant order 0, 1, 3, 0, 1, 3; acc_data[1] = 6; grant_cnt[1] = 6.
- Parallel accumulators: in the same cycle core 0 does SET 0x10 on acc 0 and core 1 does SET 0x20 on acc 2 -> both ready; acc_data[0] = 0x10 and acc_data[2] = 0x20 the next cycle.
- Arithmetic edges:
  - acc = 0xFFFFFFFF, then ADD 1 -> 0x00000000.
  - acc = 0xFFFFFFFF (-1), then MAX 0x00000003 -> 3.
  - Then MAX 0x80000000 -> stays 3.
  - Then CLR -> 0; grant_cnt unchanged by the CLR value.
- Saturation: CNT_W = 4, 20 consecutive handshakes on acc 3 -> grant_cnt[3] stops at 15.
- Mid-operation reset: assert rst while 3 requests pend on acc 0 -> no update of acc_data; after release, ptr[0] = 0 and core 0 wins first.
